// File: rtl/sm_boot_loader.sv
// UART program loader: receives a framed image (sync, count, big-endian words, XOR checksum),
// writes it into instruction memory and holds the CPU until a checksum-verified load completes.
module sm_boot_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 6,
    parameter int TIMEOUT      = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  imWe,
    output logic [ADDR_WIDTH-1:0] imWAddr,
    output logic [31:0]           imWData,
    output logic                  cpuHold,
    output logic                  loadOk,
    output logic                  loadErr
);

    localparam int          HALF = CLKS_PER_BIT / 2;
    localparam int          CW   = $clog2(CLKS_PER_BIT);
    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {FR_IDLE, FR_COUNT, FR_DATA, FR_CSUM, FR_ERR} fr_state_t;

    rx_state_t             rx_state, rx_next;
    fr_state_t             fr_state, fr_next;

    logic                  rx_meta, rxs, rxs_d;
    logic [CW-1:0]         bit_tmr;
    logic [2:0]            bit_idx;
    logic [7:0]            rx_byte;
    logic                  byte_vld, frm_err;
    logic                  tick_half, tick_full;

    logic [TW-1:0]         tmo_cnt;
    logic                  timeout;
    logic [7:0]            n_words, word_cnt, csum;
    logic [1:0]            byte_idx;
    logic [23:0]           asm_word;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  last_byte;

    assign tick_half = (bit_tmr == CW'(HALF - 1));
    assign tick_full = (bit_tmr == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rxs_d && !rxs) rx_next = RX_START;
            RX_START: if (tick_half) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick_full) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Edge detection uses rxs_d, so a line held low after a framing error cannot restart reception.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
            rx_state <= RX_IDLE;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            byte_vld <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_d    <= rxs;
            rx_state <= rx_next;
            byte_vld <= 1'b0;
            frm_err  <= 1'b0;
            if (rx_state == RX_IDLE || rx_next != rx_state || tick_full)
                bit_tmr <= '0;
            else
                bit_tmr <= bit_tmr + CW'(1);
            if (rx_state == RX_IDLE)
                bit_idx <= '0;
            if (rx_state == RX_DATA && tick_full) begin
                rx_byte <= {rxs, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_state == RX_STOP && tick_full) begin
                byte_vld <= rxs;
                frm_err  <= !rxs;
            end
        end
    end

    assign timeout   = (tmo_cnt == TW'(TIMEOUT)) && !byte_vld;
    assign last_byte = (byte_idx == 2'd3) && (word_cnt == n_words - 8'd1);
    assign cpuHold   = (fr_state != FR_IDLE);

    always_comb begin
        fr_next = fr_state;
        case (fr_state)
            FR_IDLE: begin
                if (frm_err) fr_next = FR_ERR;
                else if (byte_vld && rx_byte == SYNC) fr_next = FR_COUNT;
            end
            FR_COUNT: begin
                if (frm_err || timeout) fr_next = FR_ERR;
                else if (byte_vld) fr_next = (rx_byte == 8'd0) ? FR_ERR : FR_DATA;
            end
            FR_DATA: begin
                if (frm_err || timeout) fr_next = FR_ERR;
                else if (byte_vld && last_byte) fr_next = FR_CSUM;
            end
            FR_CSUM: begin
                if (frm_err || timeout) fr_next = FR_ERR;
                else if (byte_vld) fr_next = (rx_byte == csum) ? FR_IDLE : FR_ERR;
            end
            FR_ERR: begin
                if (byte_vld && rx_byte == SYNC) fr_next = FR_COUNT;
            end
            default: fr_next = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_state <= FR_IDLE;
            tmo_cnt  <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            csum     <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            wr_addr  <= '0;
            imWe     <= 1'b0;
            imWAddr  <= '0;
            imWData  <= '0;
            loadOk   <= 1'b0;
            loadErr  <= 1'b0;
        end else begin
            fr_state <= fr_next;
            imWe     <= 1'b0;
            loadOk   <= 1'b0;
            if ((fr_state == FR_COUNT || fr_state == FR_DATA || fr_state == FR_CSUM) && !byte_vld)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;
            if (fr_next == FR_ERR)
                loadErr <= 1'b1;
            if (byte_vld) begin
                case (fr_state)
                    FR_COUNT: begin
                        n_words  <= rx_byte;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                        wr_addr  <= '0;
                    end
                    FR_DATA: begin
                        asm_word <= {asm_word[15:0], rx_byte};
                        csum     <= csum ^ rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imWe     <= 1'b1;
                            imWData  <= {asm_word, rx_byte};
                            imWAddr  <= wr_addr;
                            wr_addr  <= wr_addr + ADDR_WIDTH'(1);
                            word_cnt <= word_cnt + 8'd1;
                        end
                    end
                    FR_CSUM: begin
                        if (rx_byte == csum) begin
                            loadOk  <= 1'b1;
                            loadErr <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/sm_boot_loader.md
# sm_boot_loader

Serial program loader that sits upstream of the CPU's instruction memory. It receives a framed program image over a UART line, 8N1. It writes the image word by word into the instruction memory write port and holds the CPU in reset while a load is in progress. It verifies an XOR checksum before releasing the CPU. A failed load keeps the CPU held and raises an error flag.

## Interface
Parameters:
- CLKS_PER_BIT, 16 — clock cycles per UART bit; must be even and ≥ 4.
- ADDR_WIDTH, 6 — instruction memory word-address width.
- TIMEOUT, 65535 — idle cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- rx  in  1  UART receive line; asynchronous input, idles high.
- imWe  out  1  instruction memory write enable; a one-cycle pulse per word.
- imWAddr  out  ADDR_WIDTH  instruction memory word address.
- imWData  out  32  instruction word to write.
- cpuHold  out  1  active-high; the top level ORs it into the CPU reset.
- loadOk  out  1  one-cycle pulse when a load completes with a good checksum.
- loadErr  out  1  sticky error flag.

## Operation
Receiver:
- rx passes through a 2-flop synchronizer; the synchronized output is rxs.
- A falling edge of rxs in the RX idle state starts reception.
- rxs is sampled CLKS_PER_BIT/2 cycles after the edge. If it is high, the start bit is false and the receiver returns to idle.
- The 8 data bits are then sampled at CLKS_PER_BIT intervals, LSB first.
- The stop bit is sampled CLKS_PER_BIT after data bit 7.
- Stop bit = 1: an internal one-cycle pulse byteVld is produced.
- Stop bit = 0: framing error. The byte is discarded and the frame FSM goes to ERR.

Frame format:
- Sync byte 0xA5.
- Count byte N: number of 32-bit words, 1..255.
- N×4 data bytes, big-endian (MSB first).
- Checksum byte: XOR of all data bytes only (sync and count excluded).

Frame FSM states: IDLE, COUNT, DATA, CSUM, ERR.
- IDLE:
  - byteVld with 0xA5 → COUNT.
  - Any other byte is ignored.
- COUNT:
  - byte = 0 → ERR.
  - Otherwise latch N, clear the word address, byte index and checksum → DATA.
- DATA:
  - Each byte shifts into a 32-bit assembly register and is XORed into the checksum.
  - On the 4th byte of a word, imWe pulses with the assembled word; the address increments after the write.
  - After word N is written → CSUM.
- CSUM:
  - byte == checksum → pulse loadOk, clear loadErr → IDLE.
  - byte != checksum → ERR.
- ERR:
  - loadErr = 1.
  - byteVld with 0xA5 → COUNT, a new attempt; loadErr stays set until a successful load.
  - Any other byte is ignored.

Timeout and address wrap:
- In COUNT, DATA and CSUM, a cycle counter is cleared on every byteVld. When it reaches TIMEOUT → ERR.
- The address wraps modulo 2^ADDR_WIDTH. If N exceeds the memory depth, earlier words are overwritten; this is not an error.

cpuHold:
- 1 in COUNT, DATA, CSUM and ERR.
- 0 in IDLE.
- A failed image therefore never executes.

## Timing
Reset values:
- imWe = 0, imWAddr = 0, imWData = 0, loadOk = 0, loadErr = 0, cpuHold = 0.
- Frame FSM = IDLE, RX FSM = idle, synchronizer flops = 1.

Latencies:
- byteVld asserts in the cycle after the stop-bit sample.
- The frame FSM acts on byteVld in the same edge.
- imWe, imWAddr and imWData are registered. They are valid together for exactly one cycle, the cycle after the 4th byteVld of a word.
- imWAddr holds its last value between pulses.
- loadOk asserts the cycle after the checksum byteVld.
- cpuHold deasserts in that same cycle.
- cpuHold asserts the cycle after the sync byteVld.

Boundary conditions:
- The receiver rearms immediately after the stop-bit sample, so back-to-back bytes with no idle time are accepted.
- A timeout and a byteVld in the same cycle: byteVld wins and the counter clears.
- rst mid-frame: all state returns to reset values on the next edge, including an in-flight imWe.
- No partial word is ever written.
- rx held low (break): one framing error → ERR. No further start bits are detected until rxs returns high.

## Test plan
Use CLKS_PER_BIT = 4 and TIMEOUT = 200 unless noted.
1. Good load. Send A5 02 24 08 00 05 24 09 00 07, checksum = 0x24^0x08^0x05^0x24^0x09^0x07 = 0x03.
   - Expect imWe at addr 0 with data 0x24080005, then at addr 1 with data 0x24090007.
   - Expect a loadOk pulse and cpuHold 1→0 the cycle after the checksum byte.
2. Bad checksum. Same frame, last byte 0x04.
   - Both words are written; no loadOk.
   - loadErr = 1 and cpuHold stays 1.
   - Then resend the good frame: loadErr clears and cpuHold = 0.
3. Framing error. Send A5 02, then a byte with stop bit = 0.
   - FSM enters ERR; loadErr = 1; no imWe pulse.
4. Timeout. Send A5 01 24 08, then idle for 201 cycles.
   - loadErr = 1 after cycle 200; no imWe pulse.
5. Noise and false start.
   - A 1-cycle low glitch on rx in IDLE produces no byteVld.
   - Bytes 0x00 and 0xFF in IDLE produce no state change and cpuHold = 0.
6. Reset and wrap.
   - Assert rst after the 3rd data byte: all outputs return to their reset values and no imWe pulse occurs.
   - With ADDR_WIDTH = 2, a 5-word load writes addresses 0,1,2,3,0.
